// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter among NUM_REQ byte producers
// Build option: define UART_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 highest);
//   default is round-robin arbitration.
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous, active-high reset
//   req_valid   requester i offers a byte
//   req_data    byte of requester i at [8*i+7:8*i]
//   req_ready   one-hot grant, transfer when valid & ready
//   tx_en       start/hold request to the transmitter
//   tx_data     byte to the transmitter, stable while tx_en=1
//   tx_done     transmitter 1-cycle pulse: frame finished
//   fifo_count  current TX FIFO occupancy
//   busy        1 while the FSM is not IDLE or the FIFO is non-empty
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [8*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_en,
  output logic [7:0]                  tx_data,
  input  logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  logic [7:0]       req_byte [NUM_REQ];
  logic [7:0]       push_data;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Full uses the registered count, so a slot freed by this cycle's pop
  // is not offered until the next cycle.
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;

`ifdef UART_SCHED_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= wrap_idx(int'(grant_idx) + 1);
    end
  end

  assign start_idx = rr_ptr;
`endif

  // First valid requester at or after start_idx, wrapping around.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (!full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[wrap_idx(int'(start_idx) + k)]) begin
          found     = 1'b1;
          grant_idx = wrap_idx(int'(start_idx) + k);
        end
      end
      if (found) begin
        req_ready[grant_idx] = 1'b1;
      end
    end
  end

  assign push      = found;
  assign push_data = req_byte[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // tx_data only changes on pop, so it keeps the last byte sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_data <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  always_comb begin
    state_next = state;
    tx_en      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_en = 1'b1;
        if (tx_done) begin
          state_next = GAP;
        end
      end
      GAP: begin
        // one low cycle on tx_en lets the transmitter re-arm
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fifo_count = count;
  assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [3:0]  fifo_count;
  logic        busy;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        auto_en = 1'b0;
  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  int          en_cnt = 0;
  logic [7:0]  sent_q [$];

  uart_tx_scheduler #(.NUM_REQ(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  assign tx_done = auto_en ? auto_done : man_done;

  // Transmitter stand-in: done pulse 5 cycles after tx_en rises.
  always @(posedge clk) begin
    if (!auto_en || !tx_en || auto_done) begin
      auto_done <= 1'b0;
      en_cnt    <= 0;
    end else if (en_cnt == 4) begin
      auto_done <= 1'b1;
      en_cnt    <= 0;
    end else begin
      en_cnt <= en_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_en && tx_done) sent_q.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; man_done = 1'b0; auto_en = 1'b0;
    tick();
    rst = 1'b0;
    sent_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL reset_tx_en got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    do_reset();
    req_data = 16'h0055; req_valid = 2'b01; #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else pass_cnt++;
    tick();
    req_valid = 2'b00; #1;
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL single_tx_en_early got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd1) $display("FAIL single_count1 got %0d want 1", fifo_count); else pass_cnt++;
    tick();
    total_cnt++; if (tx_en !== 1'b1) $display("FAIL single_tx_en_rise got %0b want 1", tx_en); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h55) $display("FAIL single_tx_data got %h want 55", tx_data); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL single_count0 got %0d want 0", fifo_count); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (tx_en !== 1'b1) $display("FAIL single_tx_en_hold got %0b want 1", tx_en); else pass_cnt++;
    man_done = 1'b1;
    tick();
    man_done = 1'b0; #1;
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL single_tx_en_fall got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_gap got %0b want 1", busy); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h55) $display("FAIL single_data_kept got %h want 55", tx_data); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_idle got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (sent_q.size() != 1) $display("FAIL single_sent_n got %0d want 1", sent_q.size()); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] acc [$];
    logic [7:0] exp_q [6];
    int a_n;
    int b_n;
    int cyc;
    int bad;
`ifdef UART_SCHED_FIXED_PRIO_EN
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`else
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
    a_n = 0; b_n = 0; cyc = 0; bad = 0;
    do_reset();
    auto_en = 1'b1;
    while (acc.size() < 6 && cyc < 100) begin
      req_data = {8'hB0 + b_n[7:0], 8'hA0 + a_n[7:0]};
      req_valid = 2'b11; #1;
      if (req_ready == 2'b01) begin acc.push_back(req_data[7:0]); a_n++; end
      else if (req_ready == 2'b10) begin acc.push_back(req_data[15:8]); b_n++; end
      else if (req_ready != 2'b00) bad++;
      tick(); cyc++;
    end
    req_valid = 2'b00;
    total_cnt++; if (acc.size() != 6) $display("FAIL rr_accept_n got %0d want 6", acc.size()); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL rr_onehot got %0d bad grants want 0", bad); else pass_cnt++;
    for (int i = 0; i < 6 && i < acc.size(); i++) begin
      total_cnt++; if (acc[i] !== exp_q[i]) $display("FAIL rr_order[%0d] got %h want %h", i, acc[i], exp_q[i]); else pass_cnt++;
    end
    cyc = 0;
    while (sent_q.size() < 6 && cyc < 500) begin tick(); cyc++; end
    total_cnt++; if (sent_q.size() != 6) $display("FAIL rr_sent_n got %0d want 6", sent_q.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < sent_q.size(); i++) begin
      total_cnt++; if (sent_q[i] !== exp_q[i]) $display("FAIL rr_sent[%0d] got %h want %h", i, sent_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_full();
    int k;
    k = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      req_data = {8'h00, 8'h10 + k[7:0]};
      req_valid = (k < 10) ? 2'b01 : 2'b00; #1;
      if (req_ready[0]) k++;
      tick();
    end
    req_data = {8'h00, 8'h10 + k[7:0]}; req_valid = 2'b01; #1;
    total_cnt++; if (k != 9) $display("FAIL full_taken got %0d want 9", k); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd8) $display("FAIL full_count got %0d want 8", fifo_count); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL full_ready got %b want 00", req_ready); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h10) $display("FAIL full_tx_data got %h want 10", tx_data); else pass_cnt++;
    man_done = 1'b1;
    tick();
    man_done = 1'b0; #1;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL full_ready_gap got %b want 00", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL full_no_bypass got %b want 00", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (fifo_count !== 4'd7) $display("FAIL full_count_freed got %0d want 7", fifo_count); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL full_ready_freed got %b want 01", req_ready); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h11) $display("FAIL full_next_byte got %h want 11", tx_data); else pass_cnt++;
    tick();
    total_cnt++; if (fifo_count !== 4'd8) $display("FAIL full_refill got %0d want 8", fifo_count); else pass_cnt++;
    req_valid = 2'b00;
  endtask

  task automatic test_wrap();
    int n;
    int cyc;
    n = 0; cyc = 0;
    do_reset();
    auto_en = 1'b1;
    while (sent_q.size() < 20 && cyc < 1000) begin
      req_data = {n[7:0], 8'h00};
      req_valid = (n < 20) ? 2'b10 : 2'b00; #1;
      if (req_ready[1]) n++;
      tick(); cyc++;
    end
    req_valid = 2'b00;
    total_cnt++; if (sent_q.size() != 20) $display("FAIL wrap_sent_n got %0d want 20", sent_q.size()); else pass_cnt++;
    for (int i = 0; i < 20 && i < sent_q.size(); i++) begin
      total_cnt++; if (sent_q[i] !== 8'(i)) $display("FAIL wrap_byte[%0d] got %h want %h", i, sent_q[i], 8'(i)); else pass_cnt++;
    end
    tick(); tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL wrap_busy_end got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL wrap_count_end got %0d want 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    int cyc;
    k = 0; cyc = 0;
    do_reset();
    while (k < 4 && cyc < 20) begin
      req_data = {8'h00, 8'h30 + k[7:0]}; req_valid = 2'b01; #1;
      if (req_ready[0]) k++;
      tick(); cyc++;
    end
    req_valid = 2'b00; #1;
    total_cnt++; if (fifo_count !== 4'd3) $display("FAIL midrst_pre_count got %0d want 3", fifo_count); else pass_cnt++;
    total_cnt++; if (tx_en !== 1'b1) $display("FAIL midrst_pre_tx_en got %0b want 1", tx_en); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL midrst_tx_en got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (fifo_count !== 4'd0) $display("FAIL midrst_count got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %0b want 0", busy); else pass_cnt++;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick(); tick();
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL midrst_late_tx_en got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_late_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (sent_q.size() != 0) $display("FAIL midrst_sent got %0d want 0", sent_q.size()); else pass_cnt++;
  endtask

  task automatic test_spurious_done();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      tick();
      if (tx_en !== 1'b0 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL spur_idle got %0d active cycles want 0", bad); else pass_cnt++;
    req_data = 16'h00C3; req_valid = 2'b01; #1;
    tick();
    req_valid = 2'b00;
    tick();
    total_cnt++; if (tx_en !== 1'b1 || tx_data !== 8'hC3) $display("FAIL spur_after_send got en=%0b data=%h want en=1 data=c3", tx_en, tx_data); else pass_cnt++;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL first_cycle_done got %0b want 0", tx_en); else pass_cnt++;
    total_cnt++; if (sent_q.size() != 1) $display("FAIL first_cycle_sent got %0d want 1", sent_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_full();
    test_wrap();
    test_reset_mid_frame();
    test_spurious_done();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
